// File: rtl/booth_pp_accumulator.sv
// Iterative radix-4 Booth partial-product accumulator.
// Takes five registered Booth action codes plus an unsigned multiplicand and
// adds one shifted partial product per clock into a 19-bit two's-complement
// accumulator. The low 16 bits are returned over a valid/ready handshake.
module booth_pp_accumulator #(
    parameter int unsigned Y_WIDTH    = 8,
    parameter int unsigned NUM_DIGITS = 5,
    parameter int unsigned P_WIDTH    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Y_WIDTH-1:0] y,
    input  logic [2:0]         a0,
    input  logic [2:0]         a1,
    input  logic [2:0]         a2,
    input  logic [2:0]         a3,
    input  logic [2:0]         a4,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] product,
    output logic               err
);

    // Three guard bits cover the negative excursions and the 2y magnitude.
    localparam int unsigned ACC_W = P_WIDTH + 3;
    localparam int unsigned CNT_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [Y_WIDTH-1:0] y_q;
    logic [2:0]         code_q [NUM_DIGITS];
    logic [2:0]         code_in [NUM_DIGITS];
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic               err_acc_q;
    logic               err_acc_d;

    logic               in_ready_q;
    logic               out_valid_q;
    logic [P_WIDTH-1:0] product_q;
    logic               err_q;

    logic [2:0]         code_sel;
    logic               illegal;
    logic [ACC_W-1:0]   mag;
    logic [ACC_W-1:0]   pp;

    // Gather the per-digit input codes into an indexable array.
    always_comb begin
        code_in[0] = a0;
        code_in[1] = a1;
        code_in[2] = a2;
        code_in[3] = a3;
        code_in[4] = a4;
    end

    // Select the registered action code for the digit being accumulated.
    always_comb begin
        code_sel = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                code_sel = code_q[i];
            end
        end
    end

    // Build the weighted partial product and the next accumulator value.
    always_comb begin
        illegal = code_sel[1] & code_sel[0];
        mag     = '0;
        if (!illegal) begin
            if (code_sel[1]) begin
                mag = ACC_W'(y_q) << 1;
            end else if (code_sel[0]) begin
                mag = ACC_W'(y_q);
            end
        end
        pp        = mag << {cnt_q, 1'b0};
        acc_d     = code_sel[2] ? (acc_q - pp) : (acc_q + pp);
        err_acc_d = err_acc_q | illegal;
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            y_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            err_acc_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                code_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid) begin
                        y_q        <= y;
                        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                            code_q[i] <= code_in[i];
                        end
                        acc_q      <= '0;
                        err_acc_q  <= 1'b0;
                        err_q      <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_ACC;
                    end
                end
                S_ACC: begin
                    acc_q     <= acc_d;
                    err_acc_q <= err_acc_d;
                    if (cnt_q == LAST_DIGIT) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // First DONE cycle publishes the result; later cycles hold it.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        product_q   <= acc_q[P_WIDTH-1:0];
                        err_q       <= err_acc_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign err       = err_q;

endmodule
